// File: rtl/tfe_pkg.sv
// Shared types and constants for the TFE feature path.
package tfe_pkg;

  localparam int unsigned TFE_FEAT_W = 256;
  localparam int unsigned TFE_BYTE_W = 8;
  localparam int unsigned TFE_CNT_W  = 16;

  typedef enum logic {
    FILL,
    HOLD
  } tfe_pack_state_e;

  typedef logic [TFE_CNT_W-1:0] tfe_frame_cnt_t;

endpackage

// File: rtl/tfe_pack_out_reg.sv
// Single-entry output holding register: full flag, stall on out_ready_i, one-shot valid.
module tfe_pack_out_reg #(
  parameter int unsigned W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         out_ready_i,
  output logic         can_load_o,
  output logic         valid_o,
  output logic         last_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic         last_q, last_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_o    = full_q & out_ready_i;
    last_o     = valid_o & last_q;
    can_load_o = ~full_q | out_ready_i;
    data_o     = data_q;
  end

  always_comb begin
    full_d = load_i | (full_q & ~out_ready_i);
    data_d = load_i ? data_i : data_q;
    last_d = load_i ? last_i : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/tfe_feature_packer.sv
// Packs IN_W-bit beats into OUT_W-bit feature words with end-of-frame zero padding.
// Optional build macro: TFE_PACK_BYTESWAP_EN reverses byte order within each beat.
module tfe_feature_packer
  import tfe_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = TFE_FEAT_W,
  parameter int unsigned CNT_W = $bits(tfe_frame_cnt_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_feature,
  output logic             o_feature_valid,
  input  logic             i_out_ready,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_words
);

  localparam int unsigned BEATS = OUT_W / IN_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned NBYTE = IN_W / TFE_BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  tfe_pack_state_e  state_q, state_d;
  logic             rdy_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [IN_W-1:0]  beat;
  logic [OUT_W-1:0] merged;
  logic             accept, complete;
  logic             load, load_last, can_load;
  logic [OUT_W-1:0] load_data;
  logic             out_valid, out_last;

`ifdef TFE_PACK_BYTESWAP_EN
  always_comb begin
    beat = '0;
    for (int unsigned b = 0; b < NBYTE; b++)
      beat[b*TFE_BYTE_W +: TFE_BYTE_W] = i_data[(NBYTE-1-b)*TFE_BYTE_W +: TFE_BYTE_W];
  end
`else
  always_comb beat = i_data;
`endif

  // Upper beats of acc_q are always zero here, which provides the end-of-frame pad.
  always_comb begin
    merged = acc_q;
    for (int unsigned k = 0; k < BEATS; k++)
      if (idx_q == IDX_W'(k)) merged[k*IN_W +: IN_W] = beat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (complete && !can_load) state_d = HOLD;
      HOLD:    if (can_load) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    o_ready   = rdy_q && (state_q == FILL);
    accept    = i_valid & o_ready;
    complete  = accept & (i_last | (idx_q == LAST_IDX));
    load      = (state_q == HOLD) ? can_load : (complete & can_load);
    load_data = (state_q == HOLD) ? acc_q : merged;
    load_last = (state_q == HOLD) ? last_q : i_last;
  end

  // A completed word that cannot move out stays in acc_q through HOLD and clears on transfer.
  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    last_d = last_q;
    if (accept) begin
      idx_d = complete ? '0 : idx_q + IDX_W'(1);
      acc_d = (complete && can_load) ? '0 : merged;
      if (complete) last_d = i_last;
    end else if (state_q == HOLD && can_load) begin
      acc_d = '0;
    end
  end

  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    words_d = words_q;
    if (out_valid) begin
      if (out_last) begin
        cnt_d   = '0;
        words_d = cnt_inc;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      acc_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  tfe_pack_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (load),
    .data_i      (load_data),
    .last_i      (load_last),
    .out_ready_i (i_out_ready),
    .can_load_o  (can_load),
    .valid_o     (out_valid),
    .last_o      (out_last),
    .data_o      (o_feature)
  );

  always_comb begin
    o_feature_valid = out_valid;
    o_frame_done    = out_last;
    o_frame_words   = out_last ? cnt_inc : words_q;
  end

endmodule

// File: doc/tfe_feature_packer.md
Name: tfe_feature_packer

Overview:
Upstream neighbour of the TFE feature preprocess stage. Accepts a narrow byte stream of raw unsigned 8-bit features with valid/ready handshake and packs it into 256-bit feature words (32 bytes) with a single-cycle valid strobe. It zero-pads a partial word at end-of-frame and reports per-frame word counts. Its output drives i_feature/i_feature_valid of the preprocess stage directly.

Parameters:
IN_W, 32, input beat width in bits; multiple of 8; divides OUT_W.
OUT_W, 256, packed word width; fixed at 256 for the TFE datapath.
CNT_W, 16, width of the per-frame word counter.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-low reset.
i_data  input  IN_W  input beat; byte 0 in bits [7:0].
i_valid  input  1  beat valid.
i_last  input  1  last beat of frame; qualified by i_valid.
o_ready  output  1  packer accepts a beat this cycle.
o_feature  output  OUT_W  packed feature word.
o_feature_valid  output  1  one-cycle strobe; o_feature is valid this cycle.
i_out_ready  input  1  downstream can take a word; tie high when feeding preprocess.
o_frame_done  output  1  one-cycle strobe with the last word of a frame.
o_frame_words  output  CNT_W  words emitted in the just-finished frame; valid with o_frame_done, held after.

Behaviour:
- BEATS = OUT_W/IN_W (8 at defaults). Beat k of a word lands in bits [k*IN_W+IN_W-1 : k*IN_W].
- Accept = i_valid & o_ready.
- Accumulator register plus a beat index (0..BEATS-1). One output holding register with a full flag.
- States: FILL (collecting beats), HOLD (accumulator complete; output register still full, waiting on i_out_ready).
- FILL: on accept, write beat at the current index. If index==BEATS-1 or i_last, the word completes:
  - Bytes above the current beat are zero in the completed word; pad is zero.
  - Word moves to the output register if it is empty or being drained this cycle; otherwise go to HOLD.
  - Index returns to 0 and the accumulator clears.
- HOLD: o_ready=0. Once the output register drains, the accumulator transfers and the state returns to FILL. The transfer cycle itself has o_ready=0.
- o_ready = (state==FILL).
- Output: o_feature_valid is 1 for exactly one cycle per word, in the cycle the word is first presented, provided i_out_ready=1.
  - If i_out_ready=0, the word is held and o_feature_valid asserts in the first cycle i_out_ready=1.
  - o_feature is stable while the word waits.
- Latency: the completing beat is accepted in cycle N, and o_feature_valid is asserted in cycle N+1 when not stalled.
- Frame count: an internal counter increments per emitted word.
  - When the word carrying i_last is emitted, o_frame_done pulses with it and o_frame_words = count including that word.
  - The counter then clears.
  - The counter saturates at all-ones and does not wrap.
- A full word with i_last on its final beat emits no extra pad word.
- A single beat with i_last at index 0 emits one word with bytes 4..31 zero, o_frame_words=1.
- i_last without i_valid is ignored.
- Reset (rst=0, any cycle, mid-word or in HOLD) clears all state.
  - Reset values: o_ready=0, o_feature=0, o_feature_valid=0, o_frame_done=0, o_frame_words=0; state FILL, index 0.
  - o_ready goes to 1 on the first clock after reset release.
  - Partial words are discarded.

Optional Feature:
TFE_PACK_BYTESWAP_EN: when defined, byte order within each input beat is reversed before packing (i_data[7:0] lands at the beat's top byte). Padding is unaffected. When undefined, bytes are placed unchanged. The handshake and timing are identical in both builds.

Decomposition:
- Shared package tfe_pkg:
  - TFE_FEAT_W=256 and TFE_BYTE_W=8.
  - Packer state enum (FILL, HOLD).
  - Frame counter type.
- One natural sub-module: tfe_pack_out_reg, the single-entry output holding register with full flag, stall, and one-shot valid generation. Everything else stays in the top.

Test Plan:
- Stream 8 beats 0x03020100..0x1F1E1D1C, i_out_ready=1, i_last on beat 8 -> one o_feature_valid pulse with o_feature=0x1F1E..0100 (byte n = n), o_frame_done=1, o_frame_words=1, next cycle o_ready=1.
- 3 beats 0xAABBCCDD, i_last on the 3rd -> o_feature bits [95:0]=three copies of 0xAABBCCDD, bits [255:96]=0, o_frame_words=1.
- 24 continuous beats with i_last on the last, i_out_ready=1 -> exactly 3 valid pulses, o_ready never drops, o_frame_words=3.
- i_out_ready=0 while 16 beats arrive -> first word held stable, o_ready=0 after beat 16 (HOLD). Raise i_out_ready -> words emitted in order, one pulse each, o_ready returns 1.
- Assert rst low after 5 beats, then release and send 8 fresh beats with i_last -> output equals only the fresh beats, no stale bytes, and all outputs are 0 during reset.
- With TFE_PACK_BYTESWAP_EN defined, beat 0x03020100 ×8 -> each 32-bit lane of o_feature reads 0x00010203.
